// File: rtl/led_arb.sv
// Round-robin arbiter sharing one RGB LED among N_REQ requesters.
// Each grant is shown for HOLD_CYC cycles (or held indefinitely while locked), then the LED is blanked for GAP_CYC cycles.
module led_arb #(
  parameter int N_REQ    = 4,
  parameter int HOLD_CYC = 1000,
  parameter int GAP_CYC  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] rgb_in,
  input  logic               btn,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         led_rgb,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             btn_q, btn_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       led_q, led_d;
  logic             busy_q, busy_d;

  logic             arb_found;
  logic [PW-1:0]    arb_idx;
  int               scan_idx;
  logic             btn_edge;
  logic             lock_n;

  // Search starts at ptr and wraps; the first asserted request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % N_REQ;
      if (!arb_found && req[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(scan_idx);
      end
    end
  end

  assign btn_edge = btn & ~btn_q;
  // Toggle is applied before the hold expiry check, so an edge on the last cycle can extend SHOW.
  assign lock_n   = lock_q ^ btn_edge;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    lock_d  = 1'b0;
    btn_d   = btn;
    gnt_d   = '0;
    led_d   = '0;
    busy_d  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (arb_found) begin
          state_d        = SHOW;
          win_d          = arb_idx;
          ptr_d          = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          led_d          = rgb_in[3*int'(arb_idx) +: 3];
          busy_d         = 1'b1;
        end
      end
      SHOW: begin
        if (!req[win_q]) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (lock_n) begin
          lock_d = 1'b1;
          gnt_d  = gnt_q;
          led_d  = rgb_in[3*int'(win_q) +: 3];
        end else if (cnt_q == 16'(HOLD_CYC - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          gnt_d = gnt_q;
          led_d = rgb_in[3*int'(win_q) +: 3];
        end
      end
      GAP: begin
        if (cnt_q == 16'(GAP_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      btn_q   <= 1'b0;
      gnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      btn_q   <= btn_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign led_rgb   = led_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_arb.sv
// Bench for led_arb with N_REQ=4, HOLD_CYC=4, GAP_CYC=2: vector table plus hand-written lock/reset sequences.
module tb_led_arb;

  localparam int N  = 4;
  localparam int W  = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [3*N-1:0] rgb_in;
  logic          btn;
  logic [N-1:0]  gnt;
  logic [2:0]    led_rgb;
  logic          busy;
  logic [1:0]    dbg_state;

  led_arb #(.N_REQ(N), .HOLD_CYC(4), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .rgb_in(rgb_in), .btn(btn),
    .gnt(gnt), .led_rgb(led_rgb), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] rgb;
    logic        btn;
    logic [3:0]  gnt;
    logic [2:0]  led;
    logic        busy;
    string       name;
  } vec_t;

  vec_t            vecs[$];
  logic [W-1:0]    exp_q[$];
  int              total;
  int              bad;

  task automatic add(input logic r, input logic [3:0] rq, input logic [11:0] rgb,
                     input logic b, input logic [3:0] eg, input logic [2:0] el,
                     input logic eb, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.rgb = rgb; v.btn = b;
    v.gnt = eg; v.led = el; v.busy = eb; v.name = nm;
    vecs.push_back(v);
  endtask

  // driver: apply inputs, push expectation, clock once, check just after the edge
  task automatic cyc(input logic r, input logic [3:0] rq, input logic [11:0] rgb,
                     input logic b, input logic [3:0] eg, input logic [2:0] el,
                     input logic eb, input string nm);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    rst = r; req = rq; rgb_in = rgb; btn = b;
    exp_q.push_back({eg, el, eb});
    @(posedge clk);
    #1;
    act_v = {gnt, led_rgb, busy};
    exp_v = exp_q.pop_front();
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s t=%0t: got gnt=%b led=%b busy=%b, want gnt=%b led=%b busy=%b",
               nm, $time, act_v[7:4], act_v[3:1], act_v[0], exp_v[7:4], exp_v[3:1], exp_v[0]);
    end
  endtask

  initial begin
    logic [11:0] c_rr;
    logic [3:0]  order [4];
    logic [2:0]  col [4];
    total = 0;
    bad   = 0;
    rst = 1'b1; req = '0; rgb_in = '0; btn = 1'b0;

    // single requester: 4 SHOW, 2 GAP, 1 IDLE, re-grant
    add(1, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 0, "reset");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "single_show1");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "single_show2");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "single_show3");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "single_show4");
    add(0, 4'b0001, 12'h005, 0, 4'b0000, 3'b000, 1, "single_gap1");
    add(0, 4'b0001, 12'h005, 0, 4'b0000, 3'b000, 1, "single_gap2");
    add(0, 4'b0001, 12'h005, 0, 4'b0000, 3'b000, 0, "single_idle");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "single_regrant");

    // round robin with wrap, req=1011: r3=110 r1=011 r0=101
    c_rr = {3'b110, 3'b111, 3'b011, 3'b101};
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    col   = '{3'b101, 3'b011, 3'b110, 3'b101};
    add(1, 4'b0000, c_rr, 0, 4'b0000, 3'b000, 0, "rr_reset");
    for (int g = 0; g < 4; g++) begin
      for (int s = 0; s < ((g == 3) ? 1 : 4); s++)
        add(0, 4'b1011, c_rr, 0, order[g], col[g], 1, "rr_show");
      if (g < 3) begin
        add(0, 4'b1011, c_rr, 0, 4'b0000, 3'b000, 1, "rr_gap1");
        add(0, 4'b1011, c_rr, 0, 4'b0000, 3'b000, 1, "rr_gap2");
        add(0, 4'b1011, c_rr, 0, 4'b0000, 3'b000, 0, "rr_idle");
      end
    end

    // early release: req[0] drops in the 2nd SHOW cycle
    add(1, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 0, "er_reset");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "er_show1");
    add(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "er_show2");
    add(0, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 1, "er_gap1");
    add(0, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 1, "er_gap2");
    add(0, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 0, "er_idle");

    // colour tracking; requester 1 colour must not leak
    add(1, 4'b0000, 12'h03D, 0, 4'b0000, 3'b000, 0, "col_reset");
    add(0, 4'b0001, 12'h03D, 0, 4'b0001, 3'b101, 1, "col_first");
    add(0, 4'b0001, 12'h03B, 0, 4'b0001, 3'b011, 1, "col_change");
    add(0, 4'b0001, 12'h03B, 0, 4'b0001, 3'b011, 1, "col_hold3");
    add(0, 4'b0001, 12'h03B, 0, 4'b0001, 3'b011, 1, "col_hold4");
    add(0, 4'b0001, 12'h03B, 0, 4'b0000, 3'b000, 1, "col_gap");

    foreach (vecs[i])
      cyc(vecs[i].rst, vecs[i].req, vecs[i].rgb, vecs[i].btn,
          vecs[i].gnt, vecs[i].led, vecs[i].busy, vecs[i].name);

    // lock: btn edge in IDLE ignored, pulse in 2nd SHOW cycle, second pulse 20 cycles later
    cyc(1, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 0, "lk_reset");
    cyc(0, 4'b0000, 12'h005, 1, 4'b0000, 3'b000, 0, "lk_idle_btn");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lk_show1");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lk_show2");
    cyc(0, 4'b0001, 12'h005, 1, 4'b0001, 3'b101, 1, "lk_pulse1");
    for (int i = 0; i < 19; i++) begin
      rgb_in = 12'h005;
      cyc(0, 4'b0001, 12'(($urandom_range(0, 1) == 1) ? 12'h005 : 12'hE05), 0,
          4'b0001, 3'b101, 1, "lk_held");
    end
    cyc(0, 4'b0001, 12'h005, 1, 4'b0001, 3'b101, 1, "lk_pulse2");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lk_resume1");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0000, 3'b000, 1, "lk_gap");

    // btn edge on the last hold cycle keeps SHOW; unlock on a later edge exits at once
    cyc(1, 4'b0000, 12'h005, 0, 4'b0000, 3'b000, 0, "lx_reset");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lx_show1");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lx_show2");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lx_show3");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lx_show4");
    cyc(0, 4'b0001, 12'h005, 1, 4'b0001, 3'b101, 1, "lx_expiry_lock");
    cyc(0, 4'b0001, 12'h005, 0, 4'b0001, 3'b101, 1, "lx_locked");
    cyc(0, 4'b0001, 12'h005, 1, 4'b0000, 3'b000, 1, "lx_unlock_exit");

    // reset mid-SHOW while gnt=0100, then ptr restarts at 0
    cyc(1, 4'b0000, 12'h1C0, 0, 4'b0000, 3'b000, 0, "rs_reset");
    cyc(0, 4'b0100, 12'h1C0, 0, 4'b0100, 3'b111, 1, "rs_grant2");
    cyc(1, 4'b0100, 12'h1C0, 0, 4'b0000, 3'b000, 0, "rs_mid_show");
    cyc(0, 4'b1111, 12'h1C0, 0, 4'b0001, 3'b000, 1, "rs_first_grant");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
